pipe_ctl: RTL and testbench
===========================

// Module: pipe_ctl
// PURPOSE
// - Central pipeline sequencer for the Beta 5-stage pipeline (IF, RF, EXEC, MEM, WB).
// - Drives stage stalls, PC select and the per-stage IR source muxes, including the EXEC ir_src_exec.
// - Handles four cases: load-use bubbles, taken-branch annul, exception injection at EXEC, and data-memory wait.
// PARAMETERS
// - LD_BUBBLES  1  Bubbles inserted into EXEC per load-use hazard (LD/LDR in EXEC). Legal range 1..3.
// PORTS
// - clk            in   1  Clock; all state on posedge.
// - rst_n          in   1  Asynchronous, active-low reset.
// - ld_use_hazard  in   1  RF instruction reads the destination of an LD/LDR currently in EXEC.
// - branch_taken   in   1  BEQ/BNE/JMP in RF resolved as taken.
// - exec_illop     in   1  Instruction in EXEC is an illegal opcode.
// - irq            in   1  Level interrupt request.
// - exec_super     in   1  PC[31] of the EXEC instruction; 1 masks irq.
// - dmem_req       in   1  MEM stage is issuing a load or store.
// - dmem_ack       in   1  Data memory completes the access this cycle.
// - stall_if       out  1  Hold PC and IF register.
// - stall_rf       out  1  Hold RF pipeline register.
// - stall_exec     out  1  Hold EXEC pipeline register.
// - stall_mem      out  1  Hold MEM and WB registers.
// - pc_sel         out  3  PC_SEL_{PLUS4,BRANCH,ILLOP,XADDR,RESET}.
// - ir_src_if      out  2  IR_SRC_{DATA,NOP,EXCEPT}: IR leaving IF.
// - ir_src_rf      out  2  IR source leaving RF.
// - ir_src_exec    out  2  IR source leaving EXEC.
// - perf_stall_cnt out 32  Only when PIPE_CTL_PERF_EN is defined.
// - perf_flush_cnt out 32  Only when PIPE_CTL_PERF_EN is defined.
// BEHAVIOUR
// - States:
//   - RUN: normal issue.
//   - LD_STALL: bubble counter bub_cnt is active.
//   - MEM_WAIT: frozen until dmem_ack.
//   - XCPT: one-cycle holdoff after an injection.
// - Outputs are combinational from state and inputs. Defaults: stalls 0, pc_sel = PLUS4, all ir_src = DATA.
// - rst_n low:
//   - State goes to RUN and bub_cnt to 0 immediately, even mid-stall or mid-wait.
//   - pc_sel = RESET, all ir_src = NOP, all stalls = 0.
//   - Perf counters are cleared to 0.
// - Event priority each cycle: mem-wait > exception > load-use > branch.
// - Mem-wait: dmem_req & !dmem_ack in any state.
//   - All four stalls = 1; state enters or stays MEM_WAIT; bub_cnt is frozen.
//   - On dmem_ack the wait ends the same cycle and the FSM returns to the state it was in before the wait (RUN, LD_STALL or XCPT).
// - Exception: exec_illop | (irq & !exec_super), evaluated in RUN or LD_STALL.
//   - ir_src_exec = EXCEPT; ir_src_rf = NOP; ir_src_if = NOP.
//   - pc_sel = ILLOP if exec_illop, else XADDR.
//   - Aborts a pending load-use stall (bub_cnt cleared). Next state is XCPT.
// - XCPT: irq is ignored for this cycle; a new exec_illop is still honoured. Otherwise the cycle behaves as RUN and the FSM goes to RUN.
// - Load-use (in RUN):
//   - stall_if = stall_rf = 1; ir_src_rf = NOP, so a bubble enters EXEC.
//   - bub_cnt is loaded with LD_BUBBLES-1. If it is 0, stay in RUN; else go to LD_STALL.
// - LD_STALL: same outputs as load-use; bub_cnt decrements each cycle. At bub_cnt == 1, go to RUN after this cycle.
// - Branch: branch_taken and no higher-priority event gives pc_sel = BRANCH and ir_src_if = NOP. Single cycle, no state change.
// - A branch coincident with a load-use hazard is deferred: the RF instruction is held, so the branch re-presents after the stall.
// CONFIGURATION
// - PIPE_CTL_PERF_EN defined:
//   - perf_stall_cnt increments on every cycle with any stall asserted.
//   - perf_flush_cnt increments on every cycle with any ir_src = NOP or EXCEPT (outside reset).
//   - Both counters saturate at 32'hFFFF_FFFF.
// - PIPE_CTL_PERF_EN undefined: the perf ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - beta_pkg holds:
//   - pc_sel_t (3b) and ir_src_t (2b) enums. ir_src_t encodings are identical to the existing IR_SRC_* values used by execute.
//   - pipe_state_t {RUN, LD_STALL, MEM_WAIT, XCPT}.
// - Sub-module pipe_ctl_bubble_cnt holds the bubble counter (load, decrement, freeze, clear).
// - FSM and priority logic stay in pipe_ctl.
// TESTING
// - Reset: assert rst_n=0 mid-LD_STALL -> next-sample pc_sel=RESET, ir_src_*=NOP, stalls 0. Release -> RUN with pc_sel=PLUS4.
// - LD_BUBBLES=2, pulse ld_use_hazard 1 cycle -> stall_if/rf=1 and ir_src_rf=NOP for exactly 2 cycles, then DATA.
// - branch_taken=1 alone -> pc_sel=BRANCH, ir_src_if=NOP for 1 cycle. With ld_use_hazard=1 also -> stall only, pc_sel=PLUS4.
// - irq=1, exec_super=0 -> ir_src_exec=EXCEPT, pc_sel=XADDR, IF/RF NOP. irq held next cycle -> no re-inject (XCPT). exec_super=1 -> no injection.
// - dmem_req=1, dmem_ack=0 for 3 cycles during LD_STALL -> all stalls=1 and bub_cnt frozen. On dmem_ack the stall resumes with the remaining count.
// - PERF_EN build: 5 stall cycles plus 2 flush cycles -> perf_stall_cnt=5, perf_flush_cnt=2. Preloaded max value -> no wrap.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared Beta pipeline types: PC select, IR source and sequencer state encodings.
package beta_pkg;

  typedef enum logic [2:0] {
    PC_SEL_PLUS4  = 3'd0,
    PC_SEL_BRANCH = 3'd1,
    PC_SEL_ILLOP  = 3'd2,
    PC_SEL_XADDR  = 3'd3,
    PC_SEL_RESET  = 3'd4
  } pc_sel_t;

  // Values must match the IR_SRC_* mux encodings already used by execute.
  typedef enum logic [1:0] {
    IR_SRC_DATA   = 2'd0,
    IR_SRC_NOP    = 2'd1,
    IR_SRC_EXCEPT = 2'd2
  } ir_src_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    XCPT     = 2'd3
  } pipe_state_t;

  localparam int BUB_CNT_W = 2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctl_bubble_cnt.sv
// Load-use bubble counter: clear beats load beats decrement; holding all low freezes it.
module pipe_ctl_bubble_cnt
  import beta_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [BUB_CNT_W-1:0] load_val,
  input  logic                 dec,
  input  logic                 clear,
  output logic [BUB_CNT_W-1:0] cnt
);

  logic [BUB_CNT_W-1:0] cnt_d;
  logic [BUB_CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - BUB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctl.sv
// Beta 5-stage pipeline sequencer: stalls, PC select and IR source muxes.
// Optional perf counters are built only when PIPE_CTL_PERF_EN is defined.
module pipe_ctl
  import beta_pkg::*;
#(
  parameter int LD_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_use_hazard,
  input  logic        branch_taken,
  input  logic        exec_illop,
  input  logic        irq,
  input  logic        exec_super,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        stall_if,
  output logic        stall_rf,
  output logic        stall_exec,
  output logic        stall_mem,
  output logic [2:0]  pc_sel,
  output logic [1:0]  ir_src_if,
  output logic [1:0]  ir_src_rf,
`ifdef PIPE_CTL_PERF_EN
  output logic [1:0]  ir_src_exec,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`else
  output logic [1:0]  ir_src_exec
`endif
);

  localparam logic [BUB_CNT_W-1:0] LD_LOAD = BUB_CNT_W'(LD_BUBBLES - 1);

  pipe_state_t state_d, state_q;
  pipe_state_t ret_d, ret_q;
  pipe_state_t eff_state;

  pc_sel_t pc_sel_c;
  ir_src_t ir_if_c, ir_rf_c, ir_exec_c;
  logic    stall_if_c, stall_rf_c, stall_exec_c, stall_mem_c;
  logic    mem_wait, exc_req;
  logic    bub_load, bub_dec, bub_clear;
  logic [BUB_CNT_W-1:0] bub_cnt;

  pipe_ctl_bubble_cnt u_bubble_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bub_load),
    .load_val (LD_LOAD),
    .dec      (bub_dec),
    .clear    (bub_clear),
    .cnt      (bub_cnt)
  );

  // When a memory wait ends, the cycle behaves as the state that was interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;
  assign mem_wait  = dmem_req & ~dmem_ack;
  assign exc_req   = exec_illop | (irq & ~exec_super & (eff_state != XCPT));

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    stall_if_c   = 1'b0;
    stall_rf_c   = 1'b0;
    stall_exec_c = 1'b0;
    stall_mem_c  = 1'b0;
    pc_sel_c     = PC_SEL_PLUS4;
    ir_if_c      = IR_SRC_DATA;
    ir_rf_c      = IR_SRC_DATA;
    ir_exec_c    = IR_SRC_DATA;
    bub_load     = 1'b0;
    bub_dec      = 1'b0;
    bub_clear    = 1'b0;

    if (!rst_n) begin
      state_d   = RUN;
      ret_d     = RUN;
      pc_sel_c  = PC_SEL_RESET;
      ir_if_c   = IR_SRC_NOP;
      ir_rf_c   = IR_SRC_NOP;
      ir_exec_c = IR_SRC_NOP;
    end else if (mem_wait) begin
      stall_if_c   = 1'b1;
      stall_rf_c   = 1'b1;
      stall_exec_c = 1'b1;
      stall_mem_c  = 1'b1;
      state_d      = MEM_WAIT;
      ret_d        = eff_state;
    end else if (exc_req) begin
      pc_sel_c  = exec_illop ? PC_SEL_ILLOP : PC_SEL_XADDR;
      ir_if_c   = IR_SRC_NOP;
      ir_rf_c   = IR_SRC_NOP;
      ir_exec_c = IR_SRC_EXCEPT;
      bub_clear = 1'b1;
      state_d   = XCPT;
    end else if (eff_state == LD_STALL) begin
      // RF is held here, so any taken branch in RF simply re-presents afterwards.
      stall_if_c = 1'b1;
      stall_rf_c = 1'b1;
      ir_rf_c    = IR_SRC_NOP;
      bub_dec    = 1'b1;
      state_d    = (bub_cnt <= BUB_CNT_W'(1)) ? RUN : LD_STALL;
    end else if (ld_use_hazard) begin
      stall_if_c = 1'b1;
      stall_rf_c = 1'b1;
      ir_rf_c    = IR_SRC_NOP;
      bub_load   = 1'b1;
      state_d    = (LD_LOAD == '0) ? RUN : LD_STALL;
    end else if (branch_taken) begin
      pc_sel_c = PC_SEL_BRANCH;
      ir_if_c  = IR_SRC_NOP;
      state_d  = RUN;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  assign stall_if    = stall_if_c;
  assign stall_rf    = stall_rf_c;
  assign stall_exec  = stall_exec_c;
  assign stall_mem   = stall_mem_c;
  assign pc_sel      = pc_sel_c;
  assign ir_src_if   = ir_if_c;
  assign ir_src_rf   = ir_rf_c;
  assign ir_src_exec = ir_exec_c;

`ifdef PIPE_CTL_PERF_EN
  logic [31:0] perf_stall_d, perf_stall_q;
  logic [31:0] perf_flush_d, perf_flush_q;
  logic        stall_any, flush_any;

  assign stall_any = stall_if_c | stall_rf_c | stall_exec_c | stall_mem_c;
  assign flush_any = (ir_if_c != IR_SRC_DATA) | (ir_rf_c != IR_SRC_DATA) |
                     (ir_exec_c != IR_SRC_DATA);

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_any) perf_stall_d = sat_inc32(perf_stall_q);
    if (flush_any) perf_flush_d = sat_inc32(perf_flush_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Scoreboard bench for pipe_ctl (LD_BUBBLES=2): each driven cycle queues its expected outputs.
module tb_pipe_ctl;
  import beta_pkg::*;

  typedef struct {
    string      tag;
    logic [3:0] stalls;
    logic [2:0] pc;
    logic [1:0] ir_if;
    logic [1:0] ir_rf;
    logic [1:0] ir_exec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, ld_use_hazard, branch_taken, exec_illop, irq, exec_super, dmem_req, dmem_ack;
  logic stall_if, stall_rf, stall_exec, stall_mem;
  logic [2:0] pc_sel;
  logic [1:0] ir_src_if, ir_src_rf, ir_src_exec;
`ifdef PIPE_CTL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_ctl #(.LD_BUBBLES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_use_hazard (ld_use_hazard),
    .branch_taken  (branch_taken),
    .exec_illop    (exec_illop),
    .irq           (irq),
    .exec_super    (exec_super),
    .dmem_req      (dmem_req),
    .dmem_ack      (dmem_ack),
    .stall_if      (stall_if),
    .stall_rf      (stall_rf),
    .stall_exec    (stall_exec),
    .stall_mem     (stall_mem),
    .pc_sel        (pc_sel),
    .ir_src_if     (ir_src_if),
    .ir_src_rf     (ir_src_rf),
`ifdef PIPE_CTL_PERF_EN
    .ir_src_exec   (ir_src_exec),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`else
    .ir_src_exec   (ir_src_exec)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // stim bits: {rst_n, ld_use, branch, illop, irq, super, dmem_req, dmem_ack}
  task automatic applyStimulus(input string tag, input logic [7:0] stim, input logic [3:0] stalls,
                               input pc_sel_t pc, input ir_src_t i_if, input ir_src_t i_rf, input ir_src_t i_ex);
    exp_t e;
    {rst_n, ld_use_hazard, branch_taken, exec_illop, irq, exec_super, dmem_req, dmem_ack} = stim;
    e.tag = tag; e.stalls = stalls; e.pc = pc; e.ir_if = i_if; e.ir_rf = i_rf; e.ir_exec = i_ex;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput({e.tag, ".stalls"}, 32'({stall_if, stall_rf, stall_exec, stall_mem}), 32'(e.stalls));
      checkOutput({e.tag, ".pc_sel"}, 32'(pc_sel), 32'(e.pc));
      checkOutput({e.tag, ".ir_if"}, 32'(ir_src_if), 32'(e.ir_if));
      checkOutput({e.tag, ".ir_rf"}, 32'(ir_src_rf), 32'(e.ir_rf));
      checkOutput({e.tag, ".ir_exec"}, 32'(ir_src_exec), 32'(e.ir_exec));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    {rst_n, ld_use_hazard, branch_taken, exec_illop, irq, exec_super, dmem_req, dmem_ack} = 8'h00;
    @(posedge clk);
    #1;
    applyStimulus("rst0",    8'b0000_0000, 4'b0000, PC_SEL_RESET,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_NOP);
    applyStimulus("rst1",    8'b0000_0000, 4'b0000, PC_SEL_RESET,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_NOP);
    applyStimulus("idle",    8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("br",      8'b1010_0000, 4'b0000, PC_SEL_BRANCH, IR_SRC_NOP,  IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("brend",   8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("ld",      8'b1100_0000, 4'b1100, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_NOP,  IR_SRC_DATA);
    applyStimulus("ld2",     8'b1000_0000, 4'b1100, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_NOP,  IR_SRC_DATA);
    applyStimulus("ldend",   8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("ldbr",    8'b1110_0000, 4'b1100, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_NOP,  IR_SRC_DATA);
    applyStimulus("brhold",  8'b1010_0000, 4'b1100, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_NOP,  IR_SRC_DATA);
    applyStimulus("brlate",  8'b1010_0000, 4'b0000, PC_SEL_BRANCH, IR_SRC_NOP,  IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("irq",     8'b1000_1000, 4'b0000, PC_SEL_XADDR,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_EXCEPT);
    applyStimulus("irqhold", 8'b1000_1000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("super",   8'b1000_1100, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("ill",     8'b1001_0000, 4'b0000, PC_SEL_ILLOP,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_EXCEPT);
    applyStimulus("illx",    8'b1001_0000, 4'b0000, PC_SEL_ILLOP,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_EXCEPT);
    applyStimulus("xidle",   8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("illirq",  8'b1001_1000, 4'b0000, PC_SEL_ILLOP,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_EXCEPT);
    applyStimulus("xidle2",  8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("ldab",    8'b1100_0000, 4'b1100, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_NOP,  IR_SRC_DATA);
    applyStimulus("irqab",   8'b1000_1000, 4'b0000, PC_SEL_XADDR,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_EXCEPT);
    applyStimulus("abend",   8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("mwld",    8'b1100_0000, 4'b1100, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_NOP,  IR_SRC_DATA);
    applyStimulus("mw1",     8'b1000_0010, 4'b1111, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("mw2irq",  8'b1000_1010, 4'b1111, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("mw3",     8'b1000_0010, 4'b1111, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("mwack",   8'b1000_0011, 4'b1100, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_NOP,  IR_SRC_DATA);
    applyStimulus("mwend",   8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("mwbr",    8'b1010_0010, 4'b1111, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("mwbrack", 8'b1010_0011, 4'b0000, PC_SEL_BRANCH, IR_SRC_NOP,  IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("rsld",    8'b1100_0000, 4'b1100, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_NOP,  IR_SRC_DATA);
    applyStimulus("rsmid",   8'b0000_0000, 4'b0000, PC_SEL_RESET,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_NOP);
    applyStimulus("rsrel",   8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("rsw",     8'b1000_0010, 4'b1111, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("rsw0",    8'b0000_0010, 4'b0000, PC_SEL_RESET,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_NOP);
    applyStimulus("rswrel",  8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("xi",      8'b1000_1000, 4'b0000, PC_SEL_XADDR,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_EXCEPT);
    applyStimulus("xmw",     8'b1000_1010, 4'b1111, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("xmwack",  8'b1000_1011, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("xre",     8'b1000_1000, 4'b0000, PC_SEL_XADDR,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_EXCEPT);

    applyStimulus("prst",    8'b0000_0000, 4'b0000, PC_SEL_RESET,  IR_SRC_NOP,  IR_SRC_NOP,  IR_SRC_NOP);
    for (int i = 0; i < 5; i++)
      applyStimulus("pstall", 8'b1000_0010, 4'b1111, PC_SEL_PLUS4, IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    applyStimulus("pack",    8'b1000_0011, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);
    for (int i = 0; i < 2; i++)
      applyStimulus("pbr",   8'b1010_0000, 4'b0000, PC_SEL_BRANCH, IR_SRC_NOP,  IR_SRC_DATA, IR_SRC_DATA);
`ifdef PIPE_CTL_PERF_EN
    checkOutput("perf_stall", perf_stall_cnt, 32'd5);
    checkOutput("perf_flush", perf_flush_cnt, 32'd2);
`endif
    applyStimulus("pend",    8'b1000_0000, 4'b0000, PC_SEL_PLUS4,  IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA);

    @(negedge clk);
    #1;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
